data_memory_ws: RTL and testbench

Parametrised data memory for the pipelined processor's MEM stage, replacing the single-cycle halfword-array memory. Storage is an array of 16-bit cells. It supports 16-bit and 32-bit accesses, a configurable number of wait states, and a Busy stall output to the hazard unit. It registers read data, flags out-of-range addresses, and wraps the upper half of a 32-bit access around the top of the array.

---
 rtl/data_memory_ws.sv | 146 ++++++++++++++
 tb/tb_data_memory_ws.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ws.sv
// data_memory_ws: halfword-cell data memory for the MEM stage with a
// configurable number of wait states, a Busy stall output, registered load
// data, out-of-range detection and wrap-around of 32-bit accesses.
module data_memory_ws #(
    parameter int DEPTH = 2048,
    parameter int WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MR,
    input  logic        MW,
    input  logic        Size,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_Data,
    output logic        Read_Valid,
    output logic        Busy,
    output logic        Addr_Error
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    // Request captured at acceptance; held stable while Busy.
    logic              op_wr_q;
    logic              size_q;
    logic [31:0]       addr_q;
    logic [31:0]       wd_q;

    logic [15:0]       mem [DEPTH];

    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              aerr_q;

    logic              accept;
    logic              commit;
    logic              oor;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;

    assign accept  = (state_q == ST_IDLE) && (MR || MW);
    // A reset arriving in DONE abandons the access, so commit is gated by rst.
    assign commit  = (state_q == ST_DONE) && !rst;
    assign idx     = addr_q[IDX_W-1:0];
    // Natural IDX_W-bit overflow gives the wrap from DEPTH-1 to 0.
    assign idx_nxt = idx + IDX_W'(1);
    assign oor     = |addr_q[31:IDX_W];

    assign Busy       = (state_q != ST_IDLE);
    assign Read_Data  = rdata_q;
    assign Read_Valid = rvalid_q;
    assign Addr_Error = aerr_q;

    // Next-state logic: accept in IDLE, count down wait states, commit in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request at acceptance; MW wins over MR.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_wr_q <= MW;
            size_q  <= Size;
            addr_q  <= Address;
            wd_q    <= Write_Data;
        end
    end

    // Storage write at commit; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (commit && op_wr_q && !oor) begin
            mem[idx] <= wd_q[15:0];
            if (size_q) begin
                mem[idx_nxt] <= wd_q[31:16];
            end
        end
    end

    // Registered load data and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            rvalid_q <= commit && !op_wr_q;
            aerr_q   <= commit && oor;
            if (commit && !op_wr_q) begin
                if (oor) begin
                    rdata_q <= 32'h0;
                end else if (size_q) begin
                    rdata_q <= {mem[idx_nxt], mem[idx]};
                end else begin
                    rdata_q <= {16'h0, mem[idx]};
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws: three instances (WAIT = 1, 3, 0) driven by
// directed sequences and random traffic, checked every cycle against a
// timestamp-based reference model plus literal expectations.
module tb_data_memory_ws;

    localparam int DEPTH = 2048;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        mr  [3];
    logic        mw  [3];
    logic        sz  [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic [31:0] rd  [3];
    logic        rv  [3];
    logic        bsy [3];
    logic        ae  [3];

    data_memory_ws #(.DEPTH(DEPTH), .WAIT(1)) u_w1 (
        .clk(clk), .rst(rst[0]), .MR(mr[0]), .MW(mw[0]), .Size(sz[0]),
        .Address(ad[0]), .Write_Data(wd[0]), .Read_Data(rd[0]),
        .Read_Valid(rv[0]), .Busy(bsy[0]), .Addr_Error(ae[0]));

    data_memory_ws #(.DEPTH(DEPTH), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst[1]), .MR(mr[1]), .MW(mw[1]), .Size(sz[1]),
        .Address(ad[1]), .Write_Data(wd[1]), .Read_Data(rd[1]),
        .Read_Valid(rv[1]), .Busy(bsy[1]), .Addr_Error(ae[1]));

    data_memory_ws #(.DEPTH(DEPTH), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst[2]), .MR(mr[2]), .MW(mw[2]), .Size(sz[2]),
        .Address(ad[2]), .Write_Data(wd[2]), .Read_Data(rd[2]),
        .Read_Valid(rv[2]), .Busy(bsy[2]), .Addr_Error(ae[2]));

    function automatic int wv(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int k, input logic [31:0] act,
                         input logic [31:0] exp, input logic [31:0] mask);
        n_chk++;
        if ((act & mask) === (exp & mask)) n_pass++;
        else $display("FAIL %s dut%0d(WAIT=%0d): got %h required %h (mask %h) t=%0t",
                      nm, k, wv(k), act, exp, mask, $time);
    endtask

    // Reference model: memory image, known-cell map, and one pending access
    // per instance described by its acceptance cycle.
    logic [15:0] mm [3][DEPTH];
    bit          kn [3][DEPTH];
    bit          chk_en [3];
    bit          pend   [3];
    int          acc    [3];
    bit          p_wr   [3];
    bit          p_sz   [3];
    logic [31:0] p_ad   [3];
    logic [31:0] p_wd   [3];
    logic [31:0] e_rd   [3];
    logic [31:0] e_msk  [3];
    int          cyc = 0;

    always @(negedge clk) begin
        bit eb, dn, oo;
        int i0, i1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            eb = pend[k] && (cyc <= acc[k] + wv(k) + 1);
            dn = pend[k] && (cyc == acc[k] + wv(k) + 2);
            oo = 1'b0;
            if (dn) begin
                pend[k] = 1'b0;
                oo = (p_ad[k] >= DEPTH);
                i0 = int'(p_ad[k] % DEPTH);
                i1 = (i0 + 1) % DEPTH;
                if (p_wr[k]) begin
                    if (!oo) begin
                        mm[k][i0] = p_wd[k][15:0];
                        kn[k][i0] = 1'b1;
                        if (p_sz[k]) begin
                            mm[k][i1] = p_wd[k][31:16];
                            kn[k][i1] = 1'b1;
                        end
                    end
                end else if (oo) begin
                    e_rd[k]  = 32'h0;
                    e_msk[k] = ALL;
                end else if (p_sz[k]) begin
                    e_rd[k]  = {mm[k][i1], mm[k][i0]};
                    e_msk[k] = {kn[k][i1] ? 16'hFFFF : 16'h0, kn[k][i0] ? 16'hFFFF : 16'h0};
                end else begin
                    e_rd[k]  = {16'h0, mm[k][i0]};
                    e_msk[k] = {16'hFFFF, kn[k][i0] ? 16'hFFFF : 16'h0};
                end
            end
            if (chk_en[k]) begin
                check("Busy",       k, {31'b0, bsy[k]}, {31'b0, eb}, ALL);
                check("Read_Valid", k, {31'b0, rv[k]},  {31'b0, dn && !p_wr[k]}, ALL);
                check("Addr_Error", k, {31'b0, ae[k]},  {31'b0, dn && oo}, ALL);
                check("Read_Data",  k, rd[k], e_rd[k], e_msk[k]);
            end
            if (rst[k]) begin
                chk_en[k] = 1'b1;
                pend[k]   = 1'b0;
                e_rd[k]   = 32'h0;
                e_msk[k]  = ALL;
            end else if (!pend[k] && (mr[k] || mw[k])) begin
                pend[k] = 1'b1;
                acc[k]  = cyc;
                p_wr[k] = mw[k];
                p_sz[k] = sz[k];
                p_ad[k] = ad[k];
                p_wd[k] = wd[k];
            end
        end
    end

    // One access on instance k; lat counts cycles from request to Busy low.
    task automatic access(input int k, input bit wr, input bit s,
                          input logic [31:0] a, input logic [31:0] d, input bit tog,
                          output logic [31:0] r, output bit v, output bit e,
                          output int lat);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (bsy[k] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        mr[k] = !wr; mw[k] = wr; sz[k] = s; ad[k] = a; wd[k] = d;
        lat = 0; r = 32'h0; v = 1'b0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (tog && bsy[k]) begin
                mr[k] = 1'($urandom_range(0, 1));
                mw[k] = 1'($urandom_range(0, 1));
                sz[k] = 1'($urandom_range(0, 1));
                ad[k] = 32'd10;
                wd[k] = $urandom;
            end else begin
                mr[k] = 1'b0;
                mw[k] = 1'b0;
            end
            if (!bsy[k]) begin
                lat = i; r = rd[k]; v = rv[k]; e = ae[k];
                break;
            end
        end
        check("latency", k, lat, wv(k) + 2, ALL);
    endtask

    task automatic run_directed(input int k);
        logic [31:0] r;
        bit v, e;
        int lat;
        // First read after reset: Busy for WAIT+1 cycles, data in WAIT+2.
        access(k, 0, 0, 32'd0, 32'h0, 0, r, v, e, lat);
        check("first_rv", k, {31'b0, v}, 32'd1, ALL);
        // 32-bit write then reads.
        access(k, 1, 1, 32'd5, 32'hDEADBEEF, 0, r, v, e, lat);
        check("wr_no_rv", k, {31'b0, v}, 32'd0, ALL);
        access(k, 0, 1, 32'd5, 32'h0, 0, r, v, e, lat);
        check("rd32@5", k, r, 32'hDEADBEEF, ALL);
        access(k, 0, 0, 32'd6, 32'h0, 0, r, v, e, lat);
        check("rd16@6", k, r, 32'h0000DEAD, ALL);
        // 16-bit write preserves the neighbour cell.
        access(k, 1, 0, 32'd5, 32'h12341111, 0, r, v, e, lat);
        access(k, 0, 1, 32'd5, 32'h0, 0, r, v, e, lat);
        check("rd32@5_after16", k, r, 32'hDEAD1111, ALL);
        // Wrap-around at the top cell.
        access(k, 1, 1, 32'd2047, 32'hAAAA5555, 0, r, v, e, lat);
        check("wrap_no_err", k, {31'b0, e}, 32'd0, ALL);
        access(k, 0, 1, 32'd2047, 32'h0, 0, r, v, e, lat);
        check("rd32@2047", k, r, 32'hAAAA5555, ALL);
        access(k, 0, 0, 32'd0, 32'h0, 0, r, v, e, lat);
        check("rd16@0", k, r, 32'h0000AAAA, ALL);
        check("model_mem2047", k, {16'h0, mm[k][2047]}, 32'h5555, ALL);
        check("model_mem0", k, {16'h0, mm[k][0]}, 32'hAAAA, ALL);
        // Out of range: write dropped, read returns zero, both flag error.
        access(k, 1, 1, 32'h800, 32'h99998888, 0, r, v, e, lat);
        check("oor_wr_err", k, {31'b0, e}, 32'd1, ALL);
        access(k, 0, 1, 32'h800, 32'h0, 0, r, v, e, lat);
        check("oor_rd_data", k, r, 32'h0, ALL);
        check("oor_rd_rv", k, {31'b0, v}, 32'd1, ALL);
        check("oor_rd_err", k, {31'b0, e}, 32'd1, ALL);
        access(k, 0, 0, 32'd0, 32'h0, 0, r, v, e, lat);
        check("rd16@0_after_oor", k, r, 32'h0000AAAA, ALL);
        // Reset during a pending write abandons it.
        access(k, 1, 0, 32'd10, 32'h00001234, 0, r, v, e, lat);
        @(posedge clk); #1;
        mw[k] = 1'b1; mr[k] = 1'b0; sz[k] = 1'b0; ad[k] = 32'd10; wd[k] = 32'h0000BEEF;
        @(posedge clk); #1;
        mw[k] = 1'b0; rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        check("rst_busy", k, {31'b0, bsy[k]}, 32'd0, ALL);
        check("rst_rd", k, rd[k], 32'h0, ALL);
        access(k, 0, 0, 32'd10, 32'h0, 0, r, v, e, lat);
        check("rd16@10_after_abort", k, r, 32'h00001234, ALL);
        // Requests toggled while Busy are ignored.
        access(k, 0, 1, 32'd5, 32'h0, 1, r, v, e, lat);
        check("stall_rd32@5", k, r, 32'hDEAD1111, ALL);
        access(k, 0, 0, 32'd10, 32'h0, 0, r, v, e, lat);
        check("stall_rd16@10", k, r, 32'h00001234, ALL);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 8)       return 32'(r);
        else if (r < 16) return 32'(2040 + r - 8);
        else if (r < 19) return 32'h800 + 32'($urandom_range(0, 3));
        else             return $urandom;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; mr[k] = 1'b0; mw[k] = 1'b0; sz[k] = 1'b0;
            ad[k] = 32'h0; wd[k] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("reset_Busy",       k, {31'b0, bsy[k]}, 32'd0, ALL);
            check("reset_Read_Valid", k, {31'b0, rv[k]},  32'd0, ALL);
            check("reset_Addr_Error", k, {31'b0, ae[k]},  32'd0, ALL);
            check("reset_Read_Data",  k, rd[k], 32'h0, ALL);
        end
        for (int k = 0; k < 3; k++) run_directed(k);
        // Random traffic on all instances at once, including mid-access resets.
        repeat (800) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                rst[k] = ($urandom_range(0, 60) == 0);
                mr[k]  = ($urandom_range(0, 2) == 0);
                mw[k]  = ($urandom_range(0, 3) == 0);
                sz[k]  = 1'($urandom_range(0, 1));
                ad[k]  = pick_addr();
                wd[k]  = $urandom;
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; mr[k] = 1'b0; mw[k] = 1'b0;
        end
        repeat (20) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
